// File: rtl/dff_pattern_seq_pkg.sv
// Shared definitions for the pattern sequencer: FSM states, pattern length
// and the fixed stimulus pattern lookup.
package dff_pattern_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PAT_LEN = 8;

  localparam logic [2:0] LAST_IDX = 3'(PAT_LEN - 1);

  // Fixed stimulus sequence presented to the register under test.
  function automatic logic [3:0] pattern_at(input logic [2:0] i);
    logic [3:0] v;
    v = 4'h0;
    case (i)
      3'd0: v = 4'h1;
      3'd1: v = 4'h3;
      3'd2: v = 4'hC;
      3'd3: v = 4'h9;
      3'd4: v = 4'h0;
      3'd5: v = 4'hF;
      3'd6: v = 4'hA;
      3'd7: v = 4'h5;
      default: v = 4'h0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dff_pattern_seq_step_timer.sv
// Step timer: counts the clock cycles an entry has been held and flags the
// terminal count. at_last reports the terminal value regardless of enable so
// the sequencer can keep the counter parked there while paused.
module step_timer #(
  parameter int STEP_CYCLES = 4,
  parameter int CNT_W       = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc,
  output logic at_last
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign at_last = (cnt == LAST);
  assign tc      = at_last && en;

  // Count held cycles; clear wins over enable so a terminal count restarts at 0.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dff_pattern_seq.sv
// Stimulus sequencer for the counter lab: steps through an 8-entry 4-bit
// pattern, holding each entry for STEP_CYCLES clocks, with start/stop,
// pause and loop control. All outputs are registered.
module dff_pattern_seq
  import dff_pattern_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 4,
  parameter int CNT_W       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic       loop,
  output logic [3:0] d_out,
  output logic       d_valid,
  output logic [2:0] idx,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [2:0] idx_d;
  logic [3:0] d_out_d;
  logic       busy_d, done_d;

  logic       launch;
  logic       tmr_en, tmr_clr, tc, at_last;

  // A run begins only from IDLE; start is ignored while busy or in DONE.
  assign launch = (state_q == ST_IDLE) && start && !stop;

  // Counting happens in RUN only. stop outranks the terminal count, and a hold
  // arriving at the terminal value parks the counter there so the advance
  // happens on the first RUN cycle after release.
  assign tmr_en  = (state_q == ST_RUN) && !stop && !(hold && at_last);
  assign tmr_clr = launch || tc;

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES),
    .CNT_W      (CNT_W)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (tmr_en),
    .clr    (tmr_clr),
    .tc     (tc),
    .at_last(at_last)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx     <= 3'd0;
      d_out   <= 4'h0;
      busy    <= 1'b0;
      d_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx     <= idx_d;
      d_out   <= d_out_d;
      busy    <= busy_d;
      d_valid <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic with priority stop > hold > terminal count > start.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop)                                   state_d = ST_IDLE;
        else if (hold)                              state_d = ST_PAUSE;
        else if (tc && (idx == LAST_IDX) && !loop)  state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (stop)       state_d = ST_IDLE;
        else if (!hold) state_d = ST_RUN;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Index/pattern update and status decode; values hold outside RUN.
  always_comb begin
    idx_d   = idx;
    d_out_d = d_out;
    if (launch) begin
      idx_d   = 3'd0;
      d_out_d = pattern_at(3'd0);
    end else if (tc) begin
      if (idx != LAST_IDX) begin
        idx_d   = idx + 3'd1;
        d_out_d = pattern_at(idx + 3'd1);
      end else if (loop) begin
        idx_d   = 3'd0;
        d_out_d = pattern_at(3'd0);
      end
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_dff_pattern_seq.sv
// Self-checking bench for dff_pattern_seq with STEP_CYCLES=4: directed
// scenarios plus randomized control traffic against a behavioural model.
module tb_dff_pattern_seq;

  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       rst, start, stop, hold, loop;
  logic [3:0] d_out;
  logic       d_valid, busy, done;
  logic [2:0] idx;
  logic [3:0] q_reg;

  logic [3:0] pat [8] = '{4'h1, 4'h3, 4'hC, 4'h9, 4'h0, 4'hF, 4'hA, 4'h5};

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: whether a run is active/paused, how many RUN cycles
  // the current entry still has to be shown, and the visible values.
  bit         m_active, m_paused, m_done;
  int         m_left, m_idx;
  logic [3:0] m_dout, m_dout_prev;

  always #5 clk = ~clk;

  dff_pattern_seq #(.STEP_CYCLES(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold), .loop(loop),
    .d_out(d_out), .d_valid(d_valid), .idx(idx), .busy(busy), .done(done)
  );

  // Stand-in for the dff4bit register fed by d_out.
  always_ff @(posedge clk) q_reg <= d_out;

  task automatic model_reset();
    m_active = 0; m_paused = 0; m_done = 0;
    m_left = STEP; m_idx = 0; m_dout = 4'h0; m_dout_prev = 4'h0;
  endtask

  task automatic model_step();
    bit nd;
    nd = 0;
    m_dout_prev = m_dout;
    if (m_active) begin
      if (stop) m_active = 0;
      else if (m_paused) begin
        if (!hold) m_paused = 0;
      end else if (m_left > 1) begin
        m_left--;
        if (hold) m_paused = 1;
      end else if (hold) m_paused = 1;
      else if (m_idx == 7) begin
        if (loop) begin m_idx = 0; m_left = STEP; m_dout = pat[0]; end
        else begin m_active = 0; nd = 1; end
      end else begin
        m_idx++; m_left = STEP; m_dout = pat[m_idx];
      end
    end else if (!m_done && start && !stop) begin
      m_active = 1; m_paused = 0; m_idx = 0; m_left = STEP; m_dout = pat[0];
    end
    m_done = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    start = 0; stop = 0; hold = 0; loop = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({d_out, idx, busy, d_valid, done} !== 11'd0)
      $display("FAIL reset_values: got d_out=%h idx=%0d busy=%b valid=%b done=%b, expected all zero",
               d_out, idx, busy, d_valid, done);
    start = 1; tick(); start = 0;
    for (int c = 1; c <= 12; c++) tick();
    vectors++;
    if (idx !== 3'd3)
      $display("FAIL reset_setup_idx: got %0d expected 3", idx);
    #2 rst = 1;
    #1;
    vectors++;
    if ({d_out, idx, busy, done} !== 9'd0)
      $display("FAIL reset_async: got d_out=%h idx=%0d busy=%b done=%b, expected all zero",
               d_out, idx, busy, done);
    if ({d_out, idx, busy, done} !== 9'd0) miscompares++;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_single_pass();
    do_reset();
    start = 1; tick(); start = 0;
    for (int c = 0; c < 32; c++) begin
      vectors++;
      if (d_out !== pat[c/4] || idx !== 3'(c/4) || busy !== 1'b1 || d_valid !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL single_pass c=%0d: got d_out=%h idx=%0d busy=%b done=%b, expected d_out=%h idx=%0d busy=1 done=0",
                 c, d_out, idx, busy, done, pat[c/4], c/4);
      end
      if (c > 0) begin
        vectors++;
        if (q_reg !== pat[(c-1)/4]) begin
          miscompares++;
          $display("FAIL reg_pairing c=%0d: got q=%h expected %h", c, q_reg, pat[(c-1)/4]);
        end
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || d_valid !== 1'b0 || d_out !== 4'h5 || idx !== 3'd7) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b busy=%b d_out=%h idx=%0d, expected done=1 busy=0 d_out=5 idx=7",
               done, busy, d_out, idx);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || d_out !== 4'h5) begin
      miscompares++;
      $display("FAIL after_done: got done=%b busy=%b d_out=%h, expected done=0 busy=0 d_out=5",
               done, busy, d_out);
    end
  endtask

  task automatic test_loop();
    do_reset();
    loop = 1;
    start = 1; tick(); start = 0;
    for (int c = 0; c < 64; c++) begin
      vectors++;
      if (d_out !== pat[(c%32)/4] || idx !== 3'((c%32)/4) || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL loop c=%0d: got d_out=%h idx=%0d busy=%b done=%b, expected d_out=%h idx=%0d busy=1 done=0",
                 c, d_out, idx, busy, done, pat[(c%32)/4], (c%32)/4);
      end
      tick();
    end
    stop = 1; loop = 0; tick(); stop = 0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL loop_stop: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_pause();
    logic [3:0] exp;
    do_reset();
    start = 1; tick(); start = 0;
    for (int c = 1; c <= 8; c++) tick();
    for (int i = 0; i <= 10; i++) begin
      exp = (i <= 9) ? 4'hC : 4'h9;
      vectors++;
      if (d_out !== exp || busy !== 1'b1 || d_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL pause i=%0d: got d_out=%h busy=%b valid=%b, expected d_out=%h busy=1 valid=1",
                 i, d_out, busy, d_valid, exp);
      end
      hold = (i >= 1 && i <= 6);
      tick();
    end
    hold = 0;
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_abort();
    do_reset();
    start = 1; tick(); start = 0;
    for (int c = 1; c <= 16; c++) tick();
    vectors++;
    if (idx !== 3'd4) begin
      miscompares++;
      $display("FAIL abort_setup: got idx=%0d expected 4", idx);
    end
    stop = 1; tick(); stop = 0;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (busy !== 1'b0 || d_valid !== 1'b0 || done !== 1'b0 || d_out !== 4'h0 || idx !== 3'd4) begin
        miscompares++;
        $display("FAIL abort c=%0d: got busy=%b valid=%b done=%b d_out=%h idx=%0d, expected 0 0 0 0 4",
                 c, busy, d_valid, done, d_out, idx);
      end
      tick();
    end
    start = 1; tick(); start = 0;
    vectors++;
    if (d_out !== 4'h1 || idx !== 3'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart: got d_out=%h idx=%0d busy=%b, expected 1 0 1", d_out, idx, busy);
    end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    start = 1; tick(); start = 0;
    for (int c = 1; c <= 7; c++) begin
      start = (c == 3);
      tick();
      vectors++;
      if (idx !== 3'(c/4) || d_out !== pat[c/4]) begin
        miscompares++;
        $display("FAIL start_ignored c=%0d: got idx=%0d d_out=%h, expected idx=%0d d_out=%h",
                 c, idx, d_out, c/4, pat[c/4]);
      end
    end
    start = 0;
    stop = 1; tick(); stop = 0;
    vectors++;
    if (busy !== 1'b0 || idx !== 3'd1 || d_out !== 4'h3 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_at_tc: got busy=%b idx=%0d d_out=%h done=%b, expected 0 1 3 0",
               busy, idx, d_out, done);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 49) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      loop  = ($urandom_range(0, 1) == 0);
      tick();
      vectors++;
      if (d_out !== m_dout || idx !== 3'(m_idx) || busy !== m_active ||
          d_valid !== m_active || done !== m_done || q_reg !== m_dout_prev) begin
        miscompares++;
        $display("FAIL random n=%0d: got d_out=%h idx=%0d busy=%b valid=%b done=%b q=%h, expected %h %0d %b %b %b %h",
                 n, d_out, idx, busy, d_valid, done, q_reg,
                 m_dout, m_idx, m_active, m_active, m_done, m_dout_prev);
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst = 1;
    model_reset();
    test_reset();
    test_single_pass();
    test_loop();
    test_pause();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
